// File: rtl/voice_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// voice_scheduler_pkg
// Shared definitions for the voice scheduler slice:
//   - default sizing constants (voices, notes, sample address, sample width)
//   - the scheduler FSM state enum
//   - the voice-slot record {active, note, addr} at default sizing
//   - idx_width(): width of an index into n items, never narrower than 1 bit
// -----------------------------------------------------------------------------
package voice_scheduler_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_NUM_NOTES  = 8;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NOTE_WIDTH = $clog2(DEF_NUM_NOTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic                      active;
    logic [DEF_NOTE_WIDTH-1:0] note;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } voice_slot_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Purely combinational slot search for note events.
//   slot_active : per-slot playing flags
//   slot_notes  : per-slot note numbers, slot k at [k*NOTE_WIDTH +: NOTE_WIDTH]
//   ev_note     : note of the offered event
//   steal_ptr   : slot to take when every slot is busy
//   on_slot     : target slot for a note-on (match > lowest free > steal)
//   on_steal    : 1 when on_slot came from the steal pointer
//   off_mask    : slots a note-off for ev_note must silence
// -----------------------------------------------------------------------------
module voice_allocator
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_WIDTH = DEF_NOTE_WIDTH,
  parameter int IDX_WIDTH  = idx_width(DEF_NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]            slot_active,
  input  logic [NUM_VOICES*NOTE_WIDTH-1:0] slot_notes,
  input  logic [NOTE_WIDTH-1:0]            ev_note,
  input  logic [IDX_WIDTH-1:0]             steal_ptr,
  output logic [IDX_WIDTH-1:0]             on_slot,
  output logic                             on_steal,
  output logic [NUM_VOICES-1:0]            off_mask
);

  // Only a playing slot counts as "holding" a note; a silenced slot keeps its
  // old note number but is free for reuse.
  logic [NUM_VOICES-1:0] match_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_match
      assign match_vec[gi] = slot_active[gi] &&
                             (slot_notes[gi*NOTE_WIDTH +: NOTE_WIDTH] == ev_note);
    end
  endgenerate

  assign off_mask = match_vec;

  logic                 match_hit;
  logic                 free_hit;
  logic [IDX_WIDTH-1:0] match_idx;
  logic [IDX_WIDTH-1:0] free_idx;

  // Scanning downwards leaves the lowest qualifying index in place.
  always_comb begin
    match_hit = 1'b0;
    free_hit  = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      if (match_vec[k]) begin
        match_hit = 1'b1;
        match_idx = IDX_WIDTH'(k);
      end
      if (!slot_active[k]) begin
        free_hit = 1'b1;
        free_idx = IDX_WIDTH'(k);
      end
    end
  end

  always_comb begin
    on_slot  = steal_ptr;
    on_steal = 1'b0;
    if (match_hit) begin
      on_slot = match_idx;
    end else if (free_hit) begin
      on_slot = free_idx;
    end else begin
      on_steal = 1'b1;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
// Time-multiplexes NUM_VOICES wavetable voices over one shared wave BRAM and
// mixes them into one signed sample per sample_tick.
//   clk_in, rst_in       : clock, asynchronous active-low reset
//   sample_tick          : starts one mix frame (accepted only when idle)
//   ev_valid/ev_on/ev_note, ev_ready : note-on/off event handshake (idle only)
//   bram_addr, bram_data : shared {note, sample} read port, BRAM_LATENCY deep
//   mix_out, mix_valid   : frame sum and its one-cycle strobe
//   voice_active         : per-slot playing flags
//   overrun              : sticky, a tick arrived while a frame was running
// Frame timing: tick at edge t -> ISSUE slots 0..N-1 -> DRAIN for the BRAM
// latency -> COMMIT -> mix_valid visible after edge t+N+L+1.
// -----------------------------------------------------------------------------
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES   = DEF_NUM_VOICES,
  parameter int NUM_NOTES    = DEF_NUM_NOTES,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BRAM_LATENCY = 2,
  localparam int NOTE_WIDTH  = $clog2(NUM_NOTES),
  localparam int MIX_WIDTH   = DATA_WIDTH + $clog2(NUM_VOICES)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sample_tick,
  input  logic                           ev_valid,
  input  logic                           ev_on,
  input  logic [NOTE_WIDTH-1:0]          ev_note,
  output logic                           ev_ready,
  output logic [NOTE_WIDTH+ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0]          bram_data,
  output logic [MIX_WIDTH-1:0]           mix_out,
  output logic                           mix_valid,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic                           overrun
);

  localparam int IDX_WIDTH   = idx_width(NUM_VOICES);
  localparam int DRAIN_WIDTH = idx_width(BRAM_LATENCY);
  localparam logic [IDX_WIDTH-1:0]   LAST_SLOT  = IDX_WIDTH'(NUM_VOICES - 1);
  localparam logic [DRAIN_WIDTH-1:0] LAST_DRAIN = DRAIN_WIDTH'(BRAM_LATENCY - 1);

  // ---------------------------------------------------------------- FSM
  sched_state_t           state_reg, state_next;
  logic [IDX_WIDTH-1:0]   slot_reg, slot_next;
  logic [DRAIN_WIDTH-1:0] drain_reg, drain_next;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
      slot_reg  <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    drain_next = drain_reg;
    unique case (state_reg)
      IDLE: begin
        if (sample_tick) begin
          state_next = ISSUE;
          slot_next  = '0;
        end
      end
      ISSUE: begin
        if (slot_reg == LAST_SLOT) begin
          state_next = DRAIN;
          drain_next = '0;
        end else begin
          slot_next = slot_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_reg == LAST_DRAIN) begin
          state_next = COMMIT;
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ev_ready = (state_reg == IDLE);

  logic ev_accept;
  assign ev_accept = ev_valid && ev_ready;

  // ---------------------------------------------------------------- voice table
  logic [NUM_VOICES-1:0]            active_vec;
  logic [NUM_VOICES*NOTE_WIDTH-1:0] notes_flat;
  logic [NOTE_WIDTH-1:0]            slot_note [NUM_VOICES];
  logic [ADDR_WIDTH-1:0]            slot_addr [NUM_VOICES];

  logic [IDX_WIDTH-1:0]  on_slot;
  logic                  on_steal;
  logic [NUM_VOICES-1:0] off_mask;
  logic [IDX_WIDTH-1:0]  steal_ptr_reg;

  voice_allocator #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_WIDTH (NOTE_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_alloc (
    .slot_active (active_vec),
    .slot_notes  (notes_flat),
    .ev_note     (ev_note),
    .steal_ptr   (steal_ptr_reg),
    .on_slot     (on_slot),
    .on_steal    (on_steal),
    .off_mask    (off_mask)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      logic                  active_reg;
      logic [NOTE_WIDTH-1:0] note_reg;
      logic [ADDR_WIDTH-1:0] addr_reg;

      // Events only land in IDLE, COMMIT never overlaps IDLE, so the three
      // update sources are mutually exclusive in time.
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          active_reg <= 1'b0;
          note_reg   <= '0;
          addr_reg   <= '0;
        end else if (ev_accept && ev_on && (on_slot == IDX_WIDTH'(gi))) begin
          active_reg <= 1'b1;
          note_reg   <= ev_note;
          addr_reg   <= '0;
        end else if (ev_accept && !ev_on && off_mask[gi]) begin
          active_reg <= 1'b0;
        end else if ((state_reg == COMMIT) && active_reg) begin
          addr_reg <= addr_reg + 1'b1;  // natural wrap gives looping playback
        end
      end

      assign active_vec[gi]                            = active_reg;
      assign notes_flat[gi*NOTE_WIDTH +: NOTE_WIDTH]   = note_reg;
      assign slot_note[gi]                             = note_reg;
      assign slot_addr[gi]                             = addr_reg;
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      steal_ptr_reg <= '0;
    end else if (ev_accept && ev_on && on_steal) begin
      steal_ptr_reg <= (steal_ptr_reg == LAST_SLOT) ? '0 : steal_ptr_reg + 1'b1;
    end
  end

  assign voice_active = active_vec;

  // ---------------------------------------------------------------- address issue
  always_comb begin
    bram_addr = '0;
    if (state_reg == ISSUE) begin
      bram_addr = {slot_note[slot_reg], slot_addr[slot_reg]};
    end
  end

  // ---------------------------------------------------------------- accumulate
  // add_pipe_reg tracks "this slot's sample counts" alongside the BRAM read,
  // so its last stage lines up with bram_data for the issued address.
  logic [BRAM_LATENCY-1:0] add_pipe_reg, add_pipe_next;
  logic                    issue_add;

  assign issue_add = (state_reg == ISSUE) && active_vec[slot_reg];

  generate
    if (BRAM_LATENCY == 1) begin : g_pipe1
      assign add_pipe_next = issue_add;
    end else begin : g_pipen
      assign add_pipe_next = {add_pipe_reg[BRAM_LATENCY-2:0], issue_add};
    end
  endgenerate

  logic signed [MIX_WIDTH-1:0] data_ext;
  logic signed [MIX_WIDTH-1:0] acc_reg;
  logic        [MIX_WIDTH-1:0] mix_reg;
  logic                        mix_valid_reg;
  logic                        overrun_reg;

  assign data_ext = MIX_WIDTH'($signed(bram_data));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      add_pipe_reg  <= '0;
      acc_reg       <= '0;
      mix_reg       <= '0;
      mix_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      add_pipe_reg  <= add_pipe_next;
      mix_valid_reg <= 1'b0;
      if (state_reg == COMMIT) begin
        mix_reg       <= acc_reg;
        mix_valid_reg <= 1'b1;
        acc_reg       <= '0;
      end else if (add_pipe_reg[BRAM_LATENCY-1]) begin
        acc_reg <= acc_reg + data_ext;
      end
      if (sample_tick && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign mix_out   = mix_reg;
  assign mix_valid = mix_valid_reg;
  assign overrun   = overrun_reg;

endmodule
